// File: rtl/dcache_ctrl_if.sv
// Signal bundle between dcache_ctrl, the CPU memory stage and the backing data memory.
// master = CPU/memory environment side, slave = the cache controller.
interface dcache_ctrl_if;
  logic         MemRead;
  logic         MemWrite;
  logic [3:0]   BE;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         Ready;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  modport master (
    output MemRead, MemWrite, BE, addr, wdata, mem_ack, mem_rdata,
    input  rdata, Ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  MemRead, MemWrite, BE, addr, wdata, mem_ack, mem_rdata,
    output rdata, Ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Defining DCACHE_STATS_EN adds the hit_count/miss_count ports and counters.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic         CLK,
  input  logic         RST,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        resp_load_q;
  logic [31:0] resp_rdata_q;

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [31:0]      data_q  [LINES][4];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            off;
  logic                  hit;
  logic                  is_load;
  logic                  load_hit;
  logic                  load_miss;
  logic                  fill_done;
  logic                  write_done;
  logic                  unused_addr;

  assign off         = bus.addr[3:2];
  assign idx         = bus.addr[INDEX_BITS+3:4];
  assign tag         = bus.addr[31:INDEX_BITS+4];
  assign unused_addr = ^bus.addr[1:0];

  // A simultaneous MemRead/MemWrite is a store, so a load needs MemWrite low.
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign is_load    = bus.MemRead && !bus.MemWrite;
  assign load_hit   = (state_q == S_IDLE) && is_load && hit;
  assign load_miss  = (state_q == S_IDLE) && is_load && !hit;
  assign fill_done  = (state_q == S_FILL) && bus.mem_ack;
  assign write_done = (state_q == S_WRITE) && bus.mem_ack;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.Ready = 1'b0;
    bus.rdata = '0;
    if (!RST) begin
      if (load_hit) begin
        bus.Ready = 1'b1;
        bus.rdata = data_q[idx][off];
      end else if (state_q == S_RESP) begin
        bus.Ready = 1'b1;
        if (resp_load_q) bus.rdata = resp_rdata_q;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

  // NOTE: state and registered outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_load_q  <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.MemWrite) begin
            state_q     <= S_WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.addr[31:2], 2'b00};
            mem_be_q    <= bus.BE;
            mem_wdata_q <= bus.wdata;
          end else if (load_miss) begin
            state_q     <= S_FILL;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {bus.addr[31:4], 4'b0000};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            resp_load_q  <= 1'b1;
            resp_rdata_q <= bus.mem_rdata[32*off +: 32];
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            resp_load_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // NOTE: tags and data are deliberately not reset; a cleared valid bit hides them and they can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[idx] <= tag;
      for (int w = 0; w < 4; w++) data_q[idx][w] <= bus.mem_rdata[32*w +: 32];
    end else if (write_done && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.BE[b]) data_q[idx][off][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (load_hit)  hit_count_q  <= hit_count_q + 32'd1;
      if (load_miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule
